// File: rtl/manta_bus_pkg.sv
// Shared types and default widths for the manta core-bus arbiter.
package manta_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
    } bus_txn_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/manta_arb_slot.sv
// One-entry request holding register for a single host.
// Captures on a request pulse, frees on grant, flags requests that find it occupied.
module manta_arb_slot import manta_bus_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              grant,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              rw,
    output logic              full,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_data,
    output logic              slot_rw,
    output logic              overflow
);

    logic accept;

    // A grant in the same cycle empties the entry, so the new request may refill it.
    assign accept = capture && (!full || grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            slot_addr <= '0;
            slot_data <= '0;
            slot_rw   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= capture && full && !grant;
            if (accept) begin
                full      <= 1'b1;
                slot_addr <= addr;
                slot_data <= data;
                slot_rw   <= rw;
            end else if (grant) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/manta_bus_arbiter.sv
// Two-host round-robin arbiter in front of the core daisy chain: one transaction
// outstanding, response matched by address/rw, synthesised error on timeout.
module manta_bus_arbiter import manta_bus_pkg::*; #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    input  logic              r0_rw_i,
    input  logic              r0_valid_i,
    output logic [DATA_W-1:0] r0_data_o,
    output logic              r0_rw_o,
    output logic              r0_valid_o,
    output logic              r0_err_o,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    input  logic              r1_rw_i,
    input  logic              r1_valid_i,
    output logic [DATA_W-1:0] r1_data_o,
    output logic              r1_rw_o,
    output logic              r1_valid_o,
    output logic              r1_err_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_rw_o,
    output logic              bus_valid_o,
    input  logic [ADDR_W-1:0] ret_addr_i,
    input  logic [DATA_W-1:0] ret_data_i,
    input  logic              ret_rw_i,
    input  logic              ret_valid_i,
    output logic              busy_o
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    arb_state_t state, state_next;

    logic              full0, full1, ovf0, ovf1;
    logic [ADDR_W-1:0] s0_addr, s1_addr, sel_addr;
    logic [DATA_W-1:0] s0_data, s1_data, sel_data;
    logic              s0_rw, s1_rw, sel_rw;
    logic              grant0, grant1, pick;
    logic              owner, last_grant;
    logic [ADDR_W-1:0] txn_addr;
    logic              txn_rw;
    logic [TW-1:0]     timer;
    logic              match, expired;
    logic              resp_err0, resp_err1;

    manta_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) slot0 (
        .clk(clk), .rst(rst), .capture(r0_valid_i), .grant(grant0),
        .addr(r0_addr_i), .data(r0_data_i), .rw(r0_rw_i),
        .full(full0), .slot_addr(s0_addr), .slot_data(s0_data), .slot_rw(s0_rw),
        .overflow(ovf0)
    );

    manta_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) slot1 (
        .clk(clk), .rst(rst), .capture(r1_valid_i), .grant(grant1),
        .addr(r1_addr_i), .data(r1_data_i), .rw(r1_rw_i),
        .full(full1), .slot_addr(s1_addr), .slot_data(s1_data), .slot_rw(s1_rw),
        .overflow(ovf1)
    );

    assign sel_addr = pick ? s1_addr : s0_addr;
    assign sel_data = pick ? s1_data : s0_data;
    assign sel_rw   = pick ? s1_rw   : s0_rw;

    assign match   = ret_valid_i && (ret_addr_i == txn_addr) && (ret_rw_i == txn_rw);
    assign expired = (timer == TMAX);
    assign busy_o  = (state == ISSUE) || (state == WAIT);

    assign r0_err_o = ovf0 | resp_err0;
    assign r1_err_o = ovf1 | resp_err1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        pick       = 1'b0;
        case (state)
            IDLE: begin
                if (full0 || full1) begin
                    pick       = (full0 && full1) ? ~last_grant : full1;
                    grant0     = ~pick;
                    grant1     = pick;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (match || expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every bus and response output is a one-cycle pulse: cleared each cycle, set on event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            txn_addr    <= '0;
            txn_rw      <= 1'b0;
            timer       <= '0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            bus_rw_o    <= 1'b0;
            bus_valid_o <= 1'b0;
            r0_data_o   <= '0;
            r0_rw_o     <= 1'b0;
            r0_valid_o  <= 1'b0;
            resp_err0   <= 1'b0;
            r1_data_o   <= '0;
            r1_rw_o     <= 1'b0;
            r1_valid_o  <= 1'b0;
            resp_err1   <= 1'b0;
        end else begin
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            bus_rw_o    <= 1'b0;
            bus_valid_o <= 1'b0;
            r0_data_o   <= '0;
            r0_rw_o     <= 1'b0;
            r0_valid_o  <= 1'b0;
            resp_err0   <= 1'b0;
            r1_data_o   <= '0;
            r1_rw_o     <= 1'b0;
            r1_valid_o  <= 1'b0;
            resp_err1   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner       <= pick;
                        last_grant  <= pick;
                        txn_addr    <= sel_addr;
                        txn_rw      <= sel_rw;
                        bus_addr_o  <= sel_addr;
                        bus_data_o  <= sel_data;
                        bus_rw_o    <= sel_rw;
                        bus_valid_o <= 1'b1;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (timer != TMAX) timer <= timer + TW'(1);
                    if (match) begin
                        if (owner) begin
                            r1_valid_o <= 1'b1;
                            r1_data_o  <= ret_data_i;
                            r1_rw_o    <= ret_rw_i;
                        end else begin
                            r0_valid_o <= 1'b1;
                            r0_data_o  <= ret_data_i;
                            r0_rw_o    <= ret_rw_i;
                        end
                    end else if (expired) begin
                        if (owner) begin
                            r1_valid_o <= 1'b1;
                            r1_rw_o    <= txn_rw;
                            resp_err1  <= 1'b1;
                        end else begin
                            r0_valid_o <= 1'b1;
                            r0_rw_o    <= txn_rw;
                            resp_err0  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Self-checking bench for manta_bus_arbiter: directed scenarios, then randomized
// host/chain traffic checked against a transaction-level scoreboard.
module tb_manta_bus_arbiter;
    import manta_bus_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r0_addr_i, r0_data_i, r1_addr_i, r1_data_i;
    logic        r0_rw_i, r0_valid_i, r1_rw_i, r1_valid_i;
    logic [15:0] r0_data_o, r1_data_o;
    logic        r0_rw_o, r0_valid_o, r0_err_o, r1_rw_o, r1_valid_o, r1_err_o;
    logic [15:0] bus_addr_o, bus_data_o, ret_addr_i, ret_data_i;
    logic        bus_rw_o, bus_valid_o, ret_rw_i, ret_valid_i, busy_o;
    logic [72:0] outs;

    manta_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i), .r0_rw_i(r0_rw_i), .r0_valid_i(r0_valid_i),
        .r0_data_o(r0_data_o), .r0_rw_o(r0_rw_o), .r0_valid_o(r0_valid_o), .r0_err_o(r0_err_o),
        .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i), .r1_rw_i(r1_rw_i), .r1_valid_i(r1_valid_i),
        .r1_data_o(r1_data_o), .r1_rw_o(r1_rw_o), .r1_valid_o(r1_valid_o), .r1_err_o(r1_err_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
        .ret_addr_i(ret_addr_i), .ret_data_i(ret_data_i), .ret_rw_i(ret_rw_i), .ret_valid_i(ret_valid_i),
        .busy_o(busy_o)
    );

    assign outs = {r0_data_o, r0_rw_o, r0_valid_o, r0_err_o, r1_data_o, r1_rw_o, r1_valid_o, r1_err_o,
                   bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o, busy_o};

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int nbus = 0, nerr0 = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus_valid_o) nbus++;
        if (r0_err_o) nerr0++;
    endtask

    task automatic clear_hosts();
        r0_addr_i = '0; r0_data_i = '0; r0_rw_i = 1'b0; r0_valid_i = 1'b0;
        r1_addr_i = '0; r1_data_i = '0; r1_rw_i = 1'b0; r1_valid_i = 1'b0;
    endtask

    task automatic ret_drive(input logic [15:0] a, input logic [15:0] d, input logic w);
        ret_addr_i = a; ret_data_i = d; ret_rw_i = w; ret_valid_i = 1'b1;
    endtask

    task automatic ret_clear();
        ret_addr_i = '0; ret_data_i = '0; ret_rw_i = 1'b0; ret_valid_i = 1'b0;
    endtask

    task automatic host_req(input int h, input logic [15:0] a, input logic [15:0] d, input logic w);
        if (h == 0) begin r0_addr_i = a; r0_data_i = d; r0_rw_i = w; r0_valid_i = 1'b1; end
        else        begin r1_addr_i = a; r1_data_i = d; r1_rw_i = w; r1_valid_i = 1'b1; end
    endtask

    function automatic logic hvalid(input int h); return (h == 0) ? r0_valid_o : r1_valid_o; endfunction
    function automatic logic herr(input int h);   return (h == 0) ? r0_err_o   : r1_err_o;   endfunction
    function automatic logic hrw(input int h);    return (h == 0) ? r0_rw_o    : r1_rw_o;    endfunction
    function automatic logic [15:0] hdata(input int h); return (h == 0) ? r0_data_o : r1_data_o; endfunction

    task automatic do_reset();
        rst = 1'b1;
        clear_hosts();
        ret_clear();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_bus(input string tag, input int limit, output logic found,
                            output logic [15:0] a, output logic [15:0] d, output logic w);
        found = 1'b0; a = '0; d = '0; w = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (bus_valid_o) begin
                found = 1'b1; a = bus_addr_o; d = bus_data_o; w = bus_rw_o;
            end
        end
        chk({tag, "_seen"}, found, 1'b1);
    endtask

    // Expect host h's transaction on the bus, return it from the chain, check the response.
    task automatic serve(input string tag, input int h, input logic [15:0] a, input logic [15:0] d,
                         input logic w, input logic [15:0] rd);
        logic        found, bw;
        logic [15:0] ba, bd;
        wait_bus(tag, 20, found, ba, bd, bw);
        chk({tag, "_addr"}, ba, a);
        chk({tag, "_data"}, bd, d);
        chk({tag, "_rw"}, bw, w);
        step();
        ret_drive(a, rd, w);
        step();
        ret_clear();
        chk({tag, "_rvalid"}, hvalid(h), 1'b1);
        chk({tag, "_rdata"}, hdata(h), rd);
        chk({tag, "_rrw"}, hrw(h), w);
        chk({tag, "_other"}, hvalid(1 - h), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found, bw;
        logic [15:0] ba, bd;
        int          b0, e0, n;
        // random-phase scoreboard
        int          hs[2];
        int          cap[2];
        bus_txn_t    req[2];
        int          last_own, ch_owner, issue_cyc, delay, h;
        logic        ch_active, silent, resp_due, exp_rw;
        logic [15:0] exp_data;
        bus_txn_t    t;

        rst = 1'b1;
        clear_hosts();
        ret_clear();

        // reset state
        step();
        step();
        chk("reset_outs", outs, '0);
        chk("reset_busy", busy_o, 1'b0);
        rst = 1'b0;
        step();

        // single read, minimum latency
        host_req(0, 16'h0001, 16'h0000, 1'b0);
        step();
        clear_hosts();
        chk("t1_not_early", bus_valid_o, 1'b0);
        step();
        chk("t1_bus_valid", bus_valid_o, 1'b1);
        chk("t1_bus_addr", bus_addr_o, 16'h0001);
        chk("t1_bus_rw", bus_rw_o, 1'b0);
        chk("t1_busy", busy_o, 1'b1);
        step();
        chk("t1_bus_pulse", bus_valid_o, 1'b0);
        step();
        ret_drive(16'h0001, 16'h000A, 1'b0);
        step();
        ret_clear();
        chk("t1_rvalid", r0_valid_o, 1'b1);
        chk("t1_rdata", r0_data_o, 16'h000A);
        chk("t1_r1_quiet", {r1_data_o, r1_rw_o, r1_valid_o, r1_err_o}, '0);
        step();
        chk("t1_rpulse", r0_valid_o, 1'b0);
        chk("t1_idle", busy_o, 1'b0);

        // simultaneous requests from reset: host 0 wins, then rotation
        do_reset();
        host_req(0, 16'h0000, 16'h0001, 1'b1);
        host_req(1, 16'h0001, 16'h0000, 1'b0);
        step();
        clear_hosts();
        serve("t2_first_r0", 0, 16'h0000, 16'h0001, 1'b1, 16'h0001);
        serve("t2_then_r1", 1, 16'h0001, 16'h0000, 1'b0, 16'h1234);
        host_req(0, 16'h0010, 16'h0000, 1'b0);
        step();
        clear_hosts();
        serve("t2_solo_r0", 0, 16'h0010, 16'h0000, 1'b0, 16'h0055);
        host_req(0, 16'h0000, 16'h0001, 1'b1);
        host_req(1, 16'h0001, 16'h0000, 1'b0);
        step();
        clear_hosts();
        serve("t2_rep_r1", 1, 16'h0001, 16'h0000, 1'b0, 16'h4321);
        serve("t2_rep_r0", 0, 16'h0000, 16'h0001, 1'b1, 16'h0002);

        // three back-to-back reads: issue, hold (refill at grant), drop
        b0 = nbus;
        e0 = nerr0;
        host_req(0, 16'h0020, 16'h0000, 1'b0); step();
        host_req(0, 16'h0021, 16'h0000, 1'b0); step();
        host_req(0, 16'h0022, 16'h0000, 1'b0); step();
        clear_hosts();
        step(); step(); step();
        ret_drive(16'h0020, 16'h00A0, 1'b0);
        step();
        ret_clear();
        chk("t3_first_resp", {r0_valid_o, r0_data_o}, {1'b1, 16'h00A0});
        serve("t3_held", 0, 16'h0021, 16'h0000, 1'b0, 16'h00A1);
        for (int i = 0; i < 6; i++) step();
        chk("t3_bus_count", nbus - b0, 2);
        chk("t3_err_count", nerr0 - e0, 1);

        // silent chain: timeout response to host 1, then normal traffic
        host_req(1, 16'h0002, 16'h0000, 1'b0);
        step();
        clear_hosts();
        found = 1'b0;
        n = 0;
        for (int i = 0; i < TMO + 10 && !found; i++) begin
            step();
            n++;
            if (r1_valid_o) found = 1'b1;
        end
        chk("t4_seen", found, 1'b1);
        chk("t4_data", r1_data_o, 16'h0000);
        chk("t4_err", r1_err_o, 1'b1);
        chk("t4_r0_quiet", r0_valid_o, 1'b0);
        chk("t4_latency", (n >= TMO) && (n <= TMO + 4), 1'b1);
        host_req(0, 16'h0003, 16'h0000, 1'b0);
        step();
        clear_hosts();
        serve("t4_after", 0, 16'h0003, 16'h0000, 1'b0, 16'h0033);
        chk("t4_after_noerr", r0_err_o, 1'b0);

        // non-matching return ignored
        host_req(0, 16'h0001, 16'h0000, 1'b0);
        step();
        clear_hosts();
        wait_bus("t5_bus", 20, found, ba, bd, bw);
        step();
        ret_drive(16'h0005, 16'h0011, 1'b0);
        step();
        ret_clear();
        chk("t5_ignored", {r0_valid_o, r1_valid_o, r0_err_o, r1_err_o}, 4'b0000);
        chk("t5_still_busy", busy_o, 1'b1);
        ret_drive(16'h0001, 16'h00FF, 1'b0);
        step();
        ret_clear();
        chk("t5_resp", {r0_valid_o, r0_data_o}, {1'b1, 16'h00FF});
        chk("t5_r1_quiet", {r1_data_o, r1_rw_o, r1_valid_o, r1_err_o}, '0);

        // asynchronous reset mid-WAIT, then a stale return
        host_req(0, 16'h0001, 16'h0000, 1'b0);
        step();
        clear_hosts();
        wait_bus("t6_bus", 20, found, ba, bd, bw);
        step();
        step();
        chk("t6_busy_before", busy_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_outs_in_reset", outs, '0);
        step();
        rst = 1'b0;
        step();
        ret_drive(16'h0001, 16'h0077, 1'b0);
        step();
        ret_clear();
        chk("t6_no_stale", {r0_valid_o, r1_valid_o}, 2'b00);
        step();
        chk("t6_outs_after", outs, '0);

        // randomized traffic against the scoreboard
        do_reset();
        hs = '{0, 0};
        cap = '{0, 0};
        last_own = 1;
        ch_active = 1'b0;
        silent = 1'b0;
        resp_due = 1'b0;
        ch_owner = 0;
        issue_cyc = 0;
        delay = 0;
        exp_data = '0;
        exp_rw = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            step();
            if (bus_valid_o) begin
                h = -1;
                for (int k = 0; k < 2; k++)
                    if (hs[k] == 1 && req[k] == {bus_addr_o, bus_data_o, bus_rw_o}) h = k;
                chk("rnd_bus_known", h >= 0, 1'b1);
                chk("rnd_one_outstanding", ch_active, 1'b0);
                if (h >= 0) begin
                    chk("rnd_bus_timing", cap[h] <= cyc - 1, 1'b1);
                    if (hs[1 - h] == 1 && cap[1 - h] <= cyc - 1)
                        chk("rnd_round_robin", h != last_own, 1'b1);
                    last_own  = h;
                    hs[h]     = 2;
                    ch_active = 1'b1;
                    ch_owner  = h;
                    issue_cyc = cyc;
                    silent    = ($urandom_range(0, 7) == 0);
                    delay     = $urandom_range(1, 4);
                end
            end
            if (resp_due) begin
                chk("rnd_resp_valid", hvalid(ch_owner), 1'b1);
                chk("rnd_resp_data", hdata(ch_owner), exp_data);
                chk("rnd_resp_rw", hrw(ch_owner), exp_rw);
                chk("rnd_resp_err", herr(ch_owner), 1'b0);
                chk("rnd_resp_other", {hvalid(1 - ch_owner), herr(1 - ch_owner)}, 2'b00);
                hs[ch_owner] = 0;
                ch_active = 1'b0;
                resp_due = 1'b0;
            end else if (ch_active && silent && hvalid(ch_owner)) begin
                chk("rnd_tmo_data", hdata(ch_owner), 16'h0000);
                chk("rnd_tmo_err", herr(ch_owner), 1'b1);
                chk("rnd_tmo_latency", (cyc - issue_cyc >= TMO) && (cyc - issue_cyc <= TMO + 4), 1'b1);
                chk("rnd_tmo_other", hvalid(1 - ch_owner), 1'b0);
                hs[ch_owner] = 0;
                ch_active = 1'b0;
            end else begin
                chk("rnd_quiet", {r0_valid_o, r1_valid_o, r0_err_o, r1_err_o}, 4'b0000);
            end
            if (ch_active && silent && (cyc - issue_cyc > TMO + 4)) begin
                chk("rnd_tmo_missing", 1'b0, 1'b1);
                hs[ch_owner] = 0;
                ch_active = 1'b0;
            end

            clear_hosts();
            ret_clear();
            if (ch_active && !resp_due) begin
                if (!silent && delay == 0) begin
                    exp_data = 16'($urandom);
                    exp_rw   = req[ch_owner].rw;
                    ret_drive(req[ch_owner].addr, exp_data, exp_rw);
                    resp_due = 1'b1;
                end else begin
                    if (delay > 0) delay--;
                    if ($urandom_range(0, 2) == 0) begin
                        if ($urandom_range(0, 1) == 0)
                            ret_drive(req[ch_owner].addr ^ 16'h0100, 16'($urandom), req[ch_owner].rw);
                        else
                            ret_drive(req[ch_owner].addr, 16'($urandom), ~req[ch_owner].rw);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (hs[k] == 0 && $urandom_range(0, 3) == 0) begin
                    t.addr = {(k == 1), 15'($urandom)};
                    t.data = 16'($urandom);
                    t.rw   = 1'($urandom_range(0, 1));
                    host_req(k, t.addr, t.data, t.rw);
                    req[k] = t;
                    hs[k]  = 1;
                    cap[k] = cyc + 1;
                end
            end
        end
        clear_hosts();
        ret_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
